// File: rtl/cc3_mem_arbiter.sv
// Arbiter sharing one synchronous single-port RAM between the 6809 CPU (fixed priority)
// and a DMA/loader master, with a starvation counter that periodically forces a DMA slot.
module cc3_mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk32_i,
    input  logic              reset_i,
    input  logic              cpu_oe_i,
    input  logic              cpu_we_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [DATA_W-1:0] cpu_wdata_i,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_wait_o,
    input  logic              dma_req_i,
    input  logic              dma_we_i,
    input  logic [ADDR_W-1:0] dma_addr_i,
    input  logic [DATA_W-1:0] dma_wdata_i,
    output logic              dma_ack_o,
    output logic [DATA_W-1:0] dma_rdata_o,
    output logic              dma_rvalid_o,
    output logic              ram_en_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_di_o,
    input  logic [DATA_W-1:0] ram_do_i
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic              cpu_req_s;
    logic              grant_cpu_s;
    logic              grant_dma_s;
    logic [3:0]        starve_q, starve_d;
    logic              cpu_rd_q, cpu_rd_d;
    logic              dma_rd_q, dma_rd_d;
    logic [DATA_W-1:0] hold_q, hold_d;

    // Grant decision and RAM port mux; reset suppresses every grant.
    always_comb begin
        cpu_req_s   = cpu_oe_i | cpu_we_i;
        grant_dma_s = 1'b0;
        grant_cpu_s = 1'b0;
        ram_en_o    = 1'b0;
        ram_we_o    = 1'b0;
        ram_addr_o  = '0;
        ram_di_o    = '0;
        if (!reset_i) begin
            grant_dma_s = dma_req_i & (~cpu_req_s | (starve_q == STARVE_LIM));
            grant_cpu_s = cpu_req_s & ~grant_dma_s;
        end else begin
            grant_dma_s = 1'b0;
            grant_cpu_s = 1'b0;
        end
        if (grant_dma_s) begin
            ram_en_o   = 1'b1;
            ram_we_o   = dma_we_i;
            ram_addr_o = dma_addr_i;
            ram_di_o   = dma_wdata_i;
        end else if (grant_cpu_s) begin
            ram_en_o   = 1'b1;
            ram_we_o   = cpu_we_i;
            ram_addr_o = cpu_addr_i;
            ram_di_o   = cpu_wdata_i;
        end else begin
            ram_en_o   = 1'b0;
        end
    end

    // Handshakes and read-data return; everything reads as zero while in reset.
    always_comb begin
        cpu_wait_o   = cpu_req_s & grant_dma_s;
        dma_ack_o    = grant_dma_s;
        cpu_rdata_o  = '0;
        dma_rdata_o  = '0;
        dma_rvalid_o = 1'b0;
        if (!reset_i) begin
            cpu_rdata_o  = cpu_rd_q ? ram_do_i : hold_q;
            dma_rvalid_o = dma_rd_q;
            dma_rdata_o  = dma_rd_q ? ram_do_i : '0;
        end else begin
            dma_rvalid_o = 1'b0;
        end
    end

    // Next-state logic for the starvation counter, read tags and CPU hold register.
    always_comb begin
        starve_d = starve_q;
        cpu_rd_d = grant_cpu_s & ~cpu_we_i;
        dma_rd_d = grant_dma_s & ~dma_we_i;
        hold_d   = (cpu_rd_q == 1'b1) ? ram_do_i : hold_q;
        if (reset_i) begin
            starve_d = 4'd0;
            cpu_rd_d = 1'b0;
            dma_rd_d = 1'b0;
            hold_d   = '0;
        end else if (!dma_req_i || grant_dma_s) begin
            starve_d = 4'd0;
        end else if (starve_q < STARVE_LIM) begin
            starve_d = starve_q + 4'd1;
        end else begin
            starve_d = starve_q;
        end
    end

    // State registers; reset is applied through the next-state logic above.
    always_ff @(posedge clk32_i) begin
        starve_q <= starve_d;
        cpu_rd_q <= cpu_rd_d;
        dma_rd_q <= dma_rd_d;
        hold_q   <= hold_d;
    end

endmodule

// File: tb/tb_cc3_mem_arbiter.sv
// Bench for cc3_mem_arbiter: directed literal checks followed by randomized traffic
// compared every cycle against a behavioural model of arbitration and memory contents.
module tb_cc3_mem_arbiter;

    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        cpu_oe_i, cpu_we_i;
    logic [15:0] cpu_addr_i;
    logic [7:0]  cpu_wdata_i, cpu_rdata_o;
    logic        cpu_wait_o;
    logic        dma_req_i, dma_we_i;
    logic [15:0] dma_addr_i;
    logic [7:0]  dma_wdata_i, dma_rdata_o;
    logic        dma_ack_o, dma_rvalid_o;
    logic        ram_en_o, ram_we_o;
    logic [15:0] ram_addr_o;
    logic [7:0]  ram_di_o, ram_do_i;

    int checks = 0;
    int errors = 0;
    bit run    = 1'b0;

    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];

    // model state
    int         m_wait;
    logic [7:0] m_cpu_last;
    bit         m_dma_pend;
    logic [7:0] m_dma_val;

    cc3_mem_arbiter #(.ADDR_W(16), .DATA_W(8), .STARVE_MAX(SMAX)) dut (
        .clk32_i(clk), .reset_i(reset_i),
        .cpu_oe_i(cpu_oe_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o), .cpu_wait_o(cpu_wait_o),
        .dma_req_i(dma_req_i), .dma_we_i(dma_we_i), .dma_addr_i(dma_addr_i),
        .dma_wdata_i(dma_wdata_i), .dma_ack_o(dma_ack_o), .dma_rdata_o(dma_rdata_o),
        .dma_rvalid_o(dma_rvalid_o), .ram_en_o(ram_en_o), .ram_we_o(ram_we_o),
        .ram_addr_o(ram_addr_o), .ram_di_o(ram_di_o), .ram_do_i(ram_do_i)
    );

    always #5 clk = ~clk;

    // Bench-side synchronous RAM
    always @(posedge clk) begin
        if (ram_en_o) begin
            if (ram_we_o) mem[ram_addr_o] <= ram_di_o;
            else          ram_do_i <= mem[ram_addr_o];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input bit rst, input bit oe, input bit we, input logic [15:0] a,
                         input logic [7:0] d, input bit dr, input bit dw,
                         input logic [15:0] da, input logic [7:0] dd);
        @(posedge clk);
        #1;
        reset_i = rst; cpu_oe_i = oe; cpu_we_i = we; cpu_addr_i = a; cpu_wdata_i = d;
        dma_req_i = dr; dma_we_i = dw; dma_addr_i = da; dma_wdata_i = dd;
    endtask

    task automatic lit_sample();
        @(negedge clk);
        #2;
    endtask

    // Per-cycle comparison against the behavioural model, then model advance.
    always @(negedge clk) begin
        if (run) begin
            bit         cpu_req, dma_wins, cpu_wins;
            logic [7:0] e_cpu_rd, e_dma_rd;
            cpu_req  = cpu_oe_i | cpu_we_i;
            dma_wins = !reset_i && dma_req_i && (!cpu_req || m_wait >= SMAX);
            cpu_wins = !reset_i && cpu_req && !dma_wins;
            e_cpu_rd = reset_i ? 8'h00 : m_cpu_last;
            e_dma_rd = (!reset_i && m_dma_pend) ? m_dma_val : 8'h00;
            chk("m_ram_en",   {31'd0, ram_en_o},   {31'd0, (dma_wins || cpu_wins)});
            chk("m_ram_we",   {31'd0, ram_we_o},   {31'd0, (dma_wins ? dma_we_i : (cpu_wins ? cpu_we_i : 1'b0))});
            chk("m_ram_addr", {16'd0, ram_addr_o}, {16'd0, (dma_wins ? dma_addr_i : (cpu_wins ? cpu_addr_i : 16'h0000))});
            chk("m_ram_di",   {24'd0, ram_di_o},   {24'd0, (dma_wins ? dma_wdata_i : (cpu_wins ? cpu_wdata_i : 8'h00))});
            chk("m_cpu_wait", {31'd0, cpu_wait_o}, {31'd0, (cpu_req && dma_wins)});
            chk("m_dma_ack",  {31'd0, dma_ack_o},  {31'd0, dma_wins});
            chk("m_cpu_rd",   {24'd0, cpu_rdata_o}, {24'd0, e_cpu_rd});
            chk("m_dma_rv",   {31'd0, dma_rvalid_o}, {31'd0, (!reset_i && m_dma_pend)});
            chk("m_dma_rd",   {24'd0, dma_rdata_o}, {24'd0, e_dma_rd});
            if (reset_i) begin
                m_wait = 0; m_cpu_last = 8'h00; m_dma_pend = 1'b0; m_dma_val = 8'h00;
            end else begin
                m_wait = (!dma_req_i || dma_wins) ? 0 : m_wait + 1;
                m_dma_pend = dma_wins && !dma_we_i;
                if (dma_wins) begin
                    if (dma_we_i) ref_mem[dma_addr_i] = dma_wdata_i;
                    else          m_dma_val = ref_mem[dma_addr_i];
                end else if (cpu_wins) begin
                    if (cpu_we_i) ref_mem[cpu_addr_i] = cpu_wdata_i;
                    else          m_cpu_last = ref_mem[cpu_addr_i];
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 65536; i++) begin
            mem[i] = 8'h00; ref_mem[i] = 8'h00;
        end
        mem[16'h0000] = 8'h86; ref_mem[16'h0000] = 8'h86;
        mem[16'h01FF] = 8'hFF; ref_mem[16'h01FF] = 8'hFF;
        ram_do_i = 8'h00;
        m_wait = 0; m_cpu_last = 8'h00; m_dma_pend = 1'b0; m_dma_val = 8'h00;
        reset_i = 1'b1; cpu_oe_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 16'h0000;
        cpu_wdata_i = 8'h00; dma_req_i = 1'b1; dma_we_i = 1'b0; dma_addr_i = 16'h0000;
        dma_wdata_i = 8'h00;
        run = 1'b1;

        // 1. reset with both masters requesting
        for (int i = 0; i < 3; i++) begin
            if (i > 0) drive(1'b1, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0000, 8'h00);
            lit_sample();
            chk("rst_en",   {31'd0, ram_en_o},   32'd0);
            chk("rst_wait", {31'd0, cpu_wait_o}, 32'd0);
            chk("rst_ack",  {31'd0, dma_ack_o},  32'd0);
            chk("rst_rd",   {24'd0, cpu_rdata_o}, 32'd0);
        end

        // 2. CPU-only write then read
        drive(1'b0, 1'b0, 1'b1, 16'h0010, 8'hA5, 1'b0, 1'b0, 16'h0000, 8'h00);
        lit_sample();
        chk("cpu_wr_we",   {31'd0, ram_we_o},   32'd1);
        chk("cpu_wr_wait", {31'd0, cpu_wait_o}, 32'd0);
        drive(1'b0, 1'b1, 1'b0, 16'h0010, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
        lit_sample();
        chk("cpu_rd_wait", {31'd0, cpu_wait_o}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
        lit_sample();
        chk("cpu_rd_data", {24'd0, cpu_rdata_o}, 32'h0000_00A5);

        // 3. starvation pattern: DMA every 5th cycle
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b1, 1'b0, 16'h0020, 8'h00, 1'b1, 1'b0, 16'h0030, 8'h00);
            lit_sample();
            chk("starve_ack",  {31'd0, dma_ack_o},  {31'd0, (i % 5 == 4)});
            chk("starve_wait", {31'd0, cpu_wait_o}, {31'd0, (i % 5 == 4)});
        end
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);

        // 4. data isolation
        drive(1'b0, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h01FF, 8'h00);
        lit_sample();
        chk("iso_ack",  {31'd0, dma_ack_o},  32'd1);
        chk("iso_cpu1", {24'd0, cpu_rdata_o}, 32'h0000_0086);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
        lit_sample();
        chk("iso_cpu2", {24'd0, cpu_rdata_o}, 32'h0000_0086);
        chk("iso_rv",   {31'd0, dma_rvalid_o}, 32'd1);
        chk("iso_drd",  {24'd0, dma_rdata_o},  32'h0000_00FF);

        // 5. DMA-only write then read
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b1, 16'h0100, 8'h3C);
        lit_sample();
        chk("dwr_ack", {31'd0, dma_ack_o}, 32'd1);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0100, 8'h00);
        lit_sample();
        chk("drd_ack", {31'd0, dma_ack_o},    32'd1);
        chk("dwr_rv",  {31'd0, dma_rvalid_o}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
        lit_sample();
        chk("drd_rv",  {31'd0, dma_rvalid_o}, 32'd1);
        chk("drd_dat", {24'd0, dma_rdata_o},  32'h0000_003C);

        // 6. reset mid-read discards the pending tag, counter restarts from zero
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 16'h0100, 8'h00);
        lit_sample();
        chk("mr_ack", {31'd0, dma_ack_o}, 32'd1);
        drive(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
        lit_sample();
        chk("mr_rv_rst", {31'd0, dma_rvalid_o}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
        lit_sample();
        chk("mr_rv_post", {31'd0, dma_rvalid_o}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 1'b0, 16'h0004, 8'h00, 1'b1, 1'b0, 16'h0005, 8'h00);
            lit_sample();
            chk("mr_starve", {31'd0, dma_ack_o}, {31'd0, (i == 4)});
        end

        // randomized traffic, checked by the model each cycle
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
                  16'($urandom_range(0, 15)), 8'($urandom),
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 2) == 0),
                  16'($urandom_range(0, 15)), 8'($urandom));
        end
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 16'h0000, 8'h00);
        lit_sample();
        run = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cc3_mem_arbiter.md
Name:
cc3_mem_arbiter

Overview:
- Shares the single-port on-chip block RAM (8-bit data, synchronous read, 1-cycle latency, EN/WE controlled) between the MC6809 core and a secondary DMA/loader master.
- Sits between the CPU bus (cpu_oe/cpu_we/cpu_addr/data) and the RAM primitive in the top level.
- The CPU has fixed priority. A starvation counter forces a DMA slot, and the CPU is stalled via a wait output.
- A hold register keeps the CPU read data stable across DMA cycles.

Parameters:
ADDR_W, 16, address width of both masters and the RAM port
DATA_W, 8, data width
STARVE_MAX, 4, consecutive denied DMA cycles before DMA is forced ahead of the CPU (1..15)

Ports:
clk32_i  in  1  system clock, all logic on rising edge
reset_i  in  1  synchronous active-high reset
cpu_oe_i  in  1  CPU read request
cpu_we_i  in  1  CPU write request
cpu_addr_i  in  ADDR_W  CPU address
cpu_wdata_i  in  DATA_W  CPU write data
cpu_rdata_o  out  DATA_W  CPU read data, held stable
cpu_wait_o  out  1  CPU request not serviced this cycle; CPU must hold its request
dma_req_i  in  1  DMA access request
dma_we_i  in  1  DMA write (1) / read (0)
dma_addr_i  in  ADDR_W  DMA address
dma_wdata_i  in  DATA_W  DMA write data
dma_ack_o  out  1  DMA access issued to RAM this cycle
dma_rdata_o  out  DATA_W  DMA read data
dma_rvalid_o  out  1  dma_rdata_o valid, one cycle after a read ack
ram_en_o  out  1  RAM enable
ram_we_o  out  1  RAM write enable
ram_addr_o  out  ADDR_W  RAM address
ram_di_o  out  DATA_W  RAM write data
ram_do_i  in  DATA_W  RAM read data, valid the cycle after an enabled read

Behaviour:
Request decode:
- cpu_req = cpu_oe_i | cpu_we_i.
- If both oe and we are high, treat the access as a write.

Grant decision (combinational, per cycle; reset_i high forces no grant):
- grant_dma = dma_req_i & (~cpu_req | starve_q == STARVE_MAX).
- grant_cpu = cpu_req & ~grant_dma.

RAM drive:
- The winner's address, data and we are muxed to the RAM port.
- ram_en_o = grant_cpu | grant_dma.
- With no grant: ram_en_o=0, ram_we_o=0, address/data=0.

Handshake outputs:
- cpu_wait_o = cpu_req & grant_dma (combinational).
- dma_ack_o = grant_dma.

Starvation counter starve_q (4 bits):
- Clears when dma_req_i=0 or grant_dma=1.
- Otherwise increments, saturating at STARVE_MAX.
- Consequence: a continuously requesting DMA master waits at most STARVE_MAX cycles while the CPU is busy.

Read tags (registered):
- cpu_rd_q <= grant_cpu & ~ram_we_o.
- dma_rd_q <= grant_dma & ~dma_we_i.

CPU read data:
- hold_q <= ram_do_i when cpu_rd_q.
- cpu_rdata_o = cpu_rd_q ? ram_do_i : hold_q.
- cpu_rdata_o therefore never shows DMA read data.

DMA read data:
- dma_rvalid_o = dma_rd_q.
- dma_rdata_o = ram_do_i when dma_rd_q, else 0.

Reset (synchronous):
- starve_q=0, cpu_rd_q=0, dma_rd_q=0, hold_q=0.
- All outputs are 0 while reset_i is high: cpu_rdata_o=0x00, cpu_wait_o=0, dma_ack_o=0, dma_rvalid_o=0, ram_en_o=0.
- A reset asserted mid-access discards the pending read tag; no rvalid is produced after reset.

Boundary conditions:
- Writes: no read tag and no rvalid.
- Back-to-back reads from either master: one per cycle, data pipelined.
- Simultaneous CPU and DMA requests with starve_q < STARVE_MAX: CPU wins, starve_q increments.
- At STARVE_MAX: DMA wins for exactly one cycle, then the counter clears.
- DMA request dropped before ack: no access, counter clears.
- STARVE_MAX is a legal value of the 4-bit counter; values outside 1..15 are unsupported.

Latency:
- Grant to RAM: 0 cycles.
- Read data: 1 cycle after grant.

Test Plan:
1. Reset: hold reset_i 3 cycles with cpu_oe_i=1 and dma_req_i=1 -> ram_en_o=0, cpu_wait_o=0, dma_ack_o=0, cpu_rdata_o=0x00 throughout.
2. CPU-only: write 0xA5 to 0x0010, then read 0x0010 -> ram_we_o=1 in the write cycle; cpu_rdata_o=0xA5 one cycle after the read grant; cpu_wait_o=0 always.
3. Starvation: cpu_oe_i and dma_req_i held high continuously (STARVE_MAX=4) -> CPU granted 4 cycles, DMA granted on the 5th with cpu_wait_o=1 and dma_ack_o=1, then the pattern repeats.
4. Data isolation: CPU reads 0x0000 (=0x86), next cycle DMA reads 0x01FF (=0xFF) -> cpu_rdata_o remains 0x86; dma_rvalid_o=1 with dma_rdata_o=0xFF one cycle after the DMA ack.
5. DMA-only: DMA write 0x3C to 0x0100, then DMA read -> dma_ack_o=1 on both cycles immediately; dma_rvalid_o=1 only for the read, with data 0x3C.
6. Reset mid-read: DMA read acked, reset_i asserted the next cycle -> dma_rvalid_o stays 0; starve_q=0 after release.
